// File: rtl/sim_ctrl_mmio_if.sv
// sim_ctrl_mmio_if: CPU data-memory load/store port plus the console byte stream
interface sim_ctrl_mmio_if;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;

    modport master (
        output mem_we, mem_re, mem_addr, mem_wdata, char_ready,
        input  mem_rdata, char_valid, char_data
    );

    modport slave (
        input  mem_we, mem_re, mem_addr, mem_wdata, char_ready,
        output mem_rdata, char_valid, char_data
    );
endinterface

// File: rtl/sim_ctrl_mmio.sv
// sim_ctrl_mmio: console FIFO, cycle counter, TOHOST run control and watchdog on the data bus
module sim_ctrl_mmio #(
    parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000
) (
    input  logic           clk,
    input  logic           rst_n,
    sim_ctrl_mmio_if.slave bus,
    output logic           o_done,
    output logic           o_pass,
    output logic           o_timeout,
    output logic [30:0]    o_fail_code
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} state_t;

    state_t        r_state;
    logic [31:0]   r_cycle;
    logic [31:0]   r_tohost;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_head;
    logic          r_ovf;

    logic          w_sel;
    logic [1:0]    w_off;
    logic          w_wr_con;
    logic          w_wr_host;
    logic          w_to;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_rnext;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_sel     = bus.mem_addr[31:4] == BASE_ADDR[31:4];
    assign w_off     = bus.mem_addr[3:2];
    assign w_unused  = ^bus.mem_addr[1:0];
    assign w_wr_con  = bus.mem_we && w_sel && w_off == 2'd0;
    assign w_wr_host = bus.mem_we && w_sel && w_off == 2'd2 && bus.mem_wdata != 32'd0;
    assign w_to      = TIMEOUT_CYCLES != 32'd0 && r_cycle == TIMEOUT_CYCLES - 32'd1;
    assign w_full    = r_count == CW'(FIFO_DEPTH);
    assign w_pop     = r_count != '0 && bus.char_ready;
    // a full FIFO still takes the byte when the head leaves in the same cycle
    assign w_push    = w_wr_con && (!w_full || w_pop);
    assign w_rnext   = r_rptr + 1'b1;
    assign w_status  = {16'd0, 8'(r_count), 4'd0, r_ovf, o_timeout, o_pass, o_done};

    assign bus.char_valid = r_count != '0;
    assign bus.char_data  = r_head;
    assign bus.mem_rdata  = !(bus.mem_re && w_sel) ? 32'd0 :
                            w_off == 2'd1 ? w_status :
                            w_off == 2'd2 ? r_tohost :
                            w_off == 2'd3 ? r_cycle : 32'd0;

    // run-control FSM: a TOHOST write beats the watchdog, CYCLE counts only while staying in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_cycle     <= 32'd0;
            r_tohost    <= 32'd0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_timeout   <= 1'b0;
            o_fail_code <= 31'd0;
        end else if (r_state == RUN) begin
            if (w_wr_host) begin
                r_tohost    <= bus.mem_wdata;
                r_state     <= bus.mem_wdata == 32'd1 ? PASS : FAIL;
                o_done      <= 1'b1;
                o_pass      <= bus.mem_wdata == 32'd1;
                o_fail_code <= bus.mem_wdata == 32'd1 ? 31'd0 : bus.mem_wdata[31:1];
            end else if (w_to) begin
                r_state   <= TIMEOUT;
                o_done    <= 1'b1;
                o_timeout <= 1'b1;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
        end
    end

    // FIFO storage needs no reset; emptiness is tracked by the count
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.mem_wdata[7:0];
    end

    // FIFO pointers, count, registered head byte and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= 8'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= w_rnext;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_wr_con && !w_push) r_ovf <= 1'b1;
            if (w_pop && r_count > CW'(1)) r_head <= r_mem[w_rnext];
            else if (w_push && (r_count == '0 || w_pop)) r_head <= bus.mem_wdata[7:0];
        end
    end
endmodule

// File: doc/sim_ctrl_mmio.md
# sim_ctrl_mmio

Memory-mapped simulation-control peripheral on the CPU data-memory bus, directly downstream of the `cpu` core's load/store port. It gives programs a console byte FIFO, a free-running cycle counter, and a TOHOST register that ends the run with a pass or fail code. A watchdog flags runaway programs. The testbench drains the console and polls `done` rather than sampling register-file internals.

## Interface
- `BASE_ADDR`, default 32'h0001_0000: 16-byte aligned base of the register window.
- `FIFO_DEPTH`, default 8: console FIFO entries; must be a power of two, at least 2.
- `TIMEOUT_CYCLES`, default 32'd1000: watchdog limit in RUN cycles; 0 disables the watchdog.
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: reset; asynchronous assert, active-low.
- `mem_we` in 1: store strobe, full-word only.
- `mem_re` in 1: load strobe.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data.
- `mem_rdata` out 32: load data; combinational.
- `char_valid` out 1: console FIFO non-empty.
- `char_data` out 8: FIFO head byte.
- `char_ready` in 1: consumer pops the head when `char_valid && char_ready`.
- `done` out 1: run ended (pass, fail or timeout).
- `pass` out 1: run ended with TOHOST == 1.
- `timeout` out 1: run ended by the watchdog.
- `fail_code` out 31: TOHOST[31:1] of a failing write.

## Operation
- Address decode:
  - Selected when `mem_addr[31:4] == BASE_ADDR[31:4]`; offset is `mem_addr[3:2]`.
  - Unselected addresses are ignored for writes and return 0 on reads.
- Registers:
  - 0x0 CONSOLE: a write pushes `mem_wdata[7:0]`. Reads return 0.
  - 0x4 STATUS, read-only: bit0 `done`, bit1 `pass`, bit2 `timeout`, bit3 overflow (sticky), bits[15:8] FIFO count.
  - 0x8 TOHOST: a write of a nonzero value ends the run. 1 means pass; any other nonzero value v means fail, with `fail_code = v[31:1]`. A write of 0 is ignored. Reads return the last accepted value.
  - 0xC CYCLE: read-only, 32-bit cycle counter.
- State machine (states RUN, PASS, FAIL, TIMEOUT; reset goes to RUN):
  - RUN → PASS on a TOHOST write of 1.
  - RUN → FAIL on a TOHOST write of another nonzero value.
  - RUN → TIMEOUT when CYCLE == TIMEOUT_CYCLES−1 and no TOHOST write occurs in that cycle. A TOHOST write in the same cycle wins.
  - PASS, FAIL and TIMEOUT are terminal until reset. TOHOST writes in these states are ignored.
  - `done` = state != RUN; `pass` = PASS; `timeout` = TIMEOUT.
- CYCLE:
  - Increments by 1 every cycle in RUN and wraps modulo 2^32.
  - Freezes on entering a terminal state.
- Console FIFO:
  - Pushes are accepted in every state.
  - A push while full is dropped and sets the sticky overflow bit. It is not dropped if a pop occurs in the same cycle; then both happen and the count is unchanged.
  - Simultaneous push and pop when empty: the push is accepted and no pop occurs, since `char_valid` was low.
  - Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
  - Writes and reads during a cycle with both `mem_we` and `mem_re` set are independent.
- Reset values:
  - State RUN; CYCLE 0; TOHOST 0; FIFO empty; overflow 0.
  - Outputs: `done`, `pass`, `timeout` = 0; `fail_code` = 0; `char_valid` = 0; `char_data` = 0; `mem_rdata` = 0 while `rst_n` is low.
- Reset asserted mid-run clears everything immediately (asynchronously), including a partially drained FIFO and a terminal state.

## Timing
- Writes take effect at the posedge where `mem_we` is sampled high. A store is visible to a load in the next cycle.
- Reads are combinational from current state, so a load in the same cycle as a store returns the pre-store value.
- `done`, `pass`, `timeout` and `fail_code` rise at the posedge that accepts the ending TOHOST write (or the timeout condition) and remain stable until reset.
- `char_data` is the registered FIFO head. It updates the cycle after a pop, or the cycle after a push into an empty FIFO.
- CYCLE read at reset release + n cycles equals n, while in RUN.

## Test plan
- Reset then idle for 3 cycles → CYCLE reads 3; STATUS reads 0; `char_valid` = 0.
- Store 'H', 'i', '\n' to 0x0 with `char_ready` = 0, then hold `char_ready` = 1 → STATUS count = 3; the bytes drain in order 0x48, 0x69, 0x0A; count returns to 0.
- 9 CONSOLE stores with FIFO_DEPTH=8 and no pops → count = 8; overflow bit set; the 9th byte is absent on drain. Repeat with a pop on the 9th cycle → all 9 bytes are delivered.
- TOHOST ← 0x15 → next cycle `done` = 1, `pass` = 0, `fail_code` = 10; CYCLE is frozen. A later TOHOST ← 1 leaves state unchanged.
- TIMEOUT_CYCLES = 50 with no TOHOST write → `timeout` and `done` rise after 50 cycles; CYCLE reads 49. Second run: TOHOST ← 1 in cycle 49 → `pass` = 1, `timeout` = 0.
- Assert `rst_n` low in FAIL state with 4 bytes queued → all outputs return to reset values without waiting for a clock edge; after release, the run restarts in RUN with CYCLE = 0.
